// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator, advanced by a pixel-enable tick on the system clock.
// Outputs are a registered decode of the counters, so they trail the counters by one clk.
`timescale 1ns/1ps
module vga_sync_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             pix_valid
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // One extra bit so a sync window ending exactly at 2**CNT_W does not truncate.
  localparam logic [CNT_W:0] H_VIS  = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_VISIBLE + H_FP);
  localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_VIS  = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_VISIBLE + V_FP);
  localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_VISIBLE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             h_wrap, v_wrap;
  logic             line_wrap_q, frame_wrap_q;
  logic [CNT_W:0]   h_ext, v_ext;
  logic             hsync_d, vsync_d, video_on_d;

  logic             hsync_q, vsync_q, video_on_q;
  logic [CNT_W-1:0] pixel_x_q, pixel_y_q;
  logic             line_start_q, frame_start_q, pix_valid_q;

  always_comb begin
    h_wrap  = pix_en && (h_cnt_q == H_LAST);
    v_wrap  = h_wrap && (v_cnt_q == V_LAST);
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      end
    end
    h_ext      = {1'b0, h_cnt_q};
    v_ext      = {1'b0, v_cnt_q};
    hsync_d    = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d    = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d = (h_ext < H_VIS) && (v_ext < V_VIS);
  end

  // Wrap flags are remembered for one clk so the strobes land with the pixel-0 decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_wrap_q   <= 1'b0;
      frame_wrap_q  <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pix_valid_q   <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_wrap_q   <= h_wrap;
      frame_wrap_q  <= v_wrap;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= h_cnt_q;
      pixel_y_q     <= v_cnt_q;
      line_start_q  <= line_wrap_q;
      frame_start_q <= frame_wrap_q;
      pix_valid_q   <= pix_en;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pix_valid   = pix_valid_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance plus a shrunken-timing instance
// (so whole frames fit in a short run), checked every clk against a tick-count model.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 6;
  localparam int S_VV = 8,  S_VF = 2, S_VS = 2, S_VB = 3;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       pv;
  } obs_t;

  typedef struct {
    int         tick;
    logic       hs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;

  logic       hsync_d, vsync_d, video_on_d, line_start_d, frame_start_d, pix_valid_d;
  logic [9:0] pixel_x_d, pixel_y_d;
  logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s, pix_valid_s;
  logic [5:0] pixel_x_s, pixel_y_s;

  int   total = 0;
  int   bad   = 0;
  int   tcnt  = 0;
  logic ep    = 1'b0;
  obs_t q_d[$];
  obs_t q_s[$];
  obs_t rst_obs;
  vec_t vt[13];

  int cyc = 0;
  int hs_run_d, hs_len_d, ls_last_d, ls_per_d;
  int vs_run_s, vs_len_s, fs_last_s, fs_per_s;

  always #5 clk = ~clk;

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync_d), .vsync(vsync_d), .video_on(video_on_d),
    .pixel_x(pixel_x_d), .pixel_y(pixel_y_d),
    .line_start(line_start_d), .frame_start(frame_start_d), .pix_valid(pix_valid_d)
  );

  vga_sync_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_ACTIVE(1'b0), .CNT_W(6)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
    .pixel_x(pixel_x_s), .pixel_y(pixel_y_s),
    .line_start(line_start_s), .frame_start(frame_start_s), .pix_valid(pix_valid_s)
  );

  // Expected outputs after the next edge, from the number of ticks counted so far.
  function automatic obs_t model(input int tp, input logic eprev, input logic en,
                                 input int hv, input int hf, input int hs, input int hb,
                                 input int vv, input int vf, input int vs, input int vb);
    int   ht, vtot, h, v;
    obs_t o;
    ht    = hv + hf + hs + hb;
    vtot  = vv + vf + vs + vb;
    h     = tp % ht;
    v     = (tp / ht) % vtot;
    o.hs  = !((h >= hv + hf) && (h < hv + hf + hs));
    o.vs  = !((v >= vv + vf) && (v < vv + vf + vs));
    o.von = (h < hv) && (v < vv);
    o.x   = 10'(h);
    o.y   = 10'(v);
    o.ls  = eprev && (tp > 0) && (h == 0);
    o.fs  = o.ls && (v == 0);
    o.pv  = en;
    return o;
  endfunction

  function automatic obs_t obs_d();
    return obs_t'({hsync_d, vsync_d, video_on_d, pixel_x_d, pixel_y_d,
                   line_start_d, frame_start_d, pix_valid_d});
  endfunction

  function automatic obs_t obs_s();
    return obs_t'({hsync_s, vsync_s, video_on_s, 4'd0, pixel_x_s, 4'd0, pixel_y_s,
                   line_start_s, frame_start_s, pix_valid_s});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic en);
    obs_t e;
    pix_en = en;
    q_d.push_back(model(tcnt, ep, en, 640, 16, 96, 48, 480, 10, 2, 33));
    q_s.push_back(model(tcnt, ep, en, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB));
    @(posedge clk);
    tcnt = tcnt + (en ? 1 : 0);
    ep   = en;
    #1;
    e = q_d.pop_front();
    chk("sb_default", 32'(obs_d()), 32'(e));
    e = q_s.pop_front();
    chk("sb_small", 32'(obs_s()), 32'(e));
    @(negedge clk);
  endtask

  task automatic mon_clear();
    hs_run_d = 0; hs_len_d = 0; ls_last_d = -1; ls_per_d = 0;
    vs_run_s = 0; vs_len_s = 0; fs_last_s = -1; fs_per_s = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (!hsync_d) hs_run_d++;
      else if (hs_run_d != 0) begin hs_len_d = hs_run_d; hs_run_d = 0; end
      if (!vsync_s) vs_run_s++;
      else if (vs_run_s != 0) begin vs_len_s = vs_run_s; vs_run_s = 0; end
      if (line_start_d) begin
        if (ls_last_d >= 0) ls_per_d = cyc - ls_last_d;
        ls_last_d = cyc;
      end
      if (frame_start_s) begin
        if (fs_last_s >= 0) fs_per_s = cyc - fs_last_s;
        fs_last_s = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_obs = '0;
    rst_obs.hs = 1'b1;
    rst_obs.vs = 1'b1;
    //        tick  hsync von  x        y
    vt[0]  = '{0,    1'b1, 1'b1, 10'd0,   10'd0};
    vt[1]  = '{100,  1'b1, 1'b1, 10'd100, 10'd0};
    vt[2]  = '{639,  1'b1, 1'b1, 10'd639, 10'd0};
    vt[3]  = '{640,  1'b1, 1'b0, 10'd640, 10'd0};
    vt[4]  = '{655,  1'b1, 1'b0, 10'd655, 10'd0};
    vt[5]  = '{656,  1'b0, 1'b0, 10'd656, 10'd0};
    vt[6]  = '{751,  1'b0, 1'b0, 10'd751, 10'd0};
    vt[7]  = '{752,  1'b1, 1'b0, 10'd752, 10'd0};
    vt[8]  = '{799,  1'b1, 1'b0, 10'd799, 10'd0};
    vt[9]  = '{800,  1'b1, 1'b1, 10'd0,   10'd1};
    vt[10] = '{1439, 1'b1, 1'b1, 10'd639, 10'd1};
    vt[11] = '{1440, 1'b1, 1'b0, 10'd640, 10'd1};
    vt[12] = '{1600, 1'b1, 1'b1, 10'd0,   10'd2};

    rst = 1'b0;
    pix_en = 1'b0;
    mon_clear();
    repeat (3) @(negedge clk);
    chk("reset_default", 32'(obs_d()), 32'(rst_obs));
    chk("reset_small", 32'(obs_s()), 32'(rst_obs));

    // Timing at 4:1, walking the checkpoint table; stall inserted at pixel 100.
    rst = 1'b1;
    step(1'b0);
    for (int i = 0; i < 13; i++) begin
      while (tcnt < vt[i].tick) begin
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
      end
      chk($sformatf("table_%0d", vt[i].tick),
          32'({hsync_d, video_on_d, pixel_x_d, pixel_y_d}),
          32'({vt[i].hs, vt[i].von, vt[i].x, vt[i].y}));
      if (vt[i].tick == 100) begin
        repeat (50) step(1'b0);
        chk("stall_x", 32'(pixel_x_d), 32'd100);
        chk("stall_pv", 32'(pix_valid_d), 32'd0);
        step(1'b1);
        chk("stall_resume_pv", 32'(pix_valid_d), 32'd1);
        step(1'b0);
        chk("stall_resume_pv_drop", 32'(pix_valid_d), 32'd0);
        chk("stall_resume_x", 32'(pixel_x_d), 32'd101);
        step(1'b0);
        step(1'b0);
      end
    end
    chk("hsync_low_clk_4to1", 32'(hs_len_d), 32'd384);
    chk("line_period_clk_4to1", 32'(ls_per_d), 32'd3200);
    chk("small_vsync_low_clk_4to1", 32'(vs_len_s), 32'd256);
    chk("small_frame_period_clk_4to1", 32'(fs_per_s), 32'd1920);

    // Mid-run asynchronous reset with pix_en still toggling.
    step(1'b1);
    step(1'b0);
    rst = 1'b0;
    #1;
    chk("midreset_async_default", 32'(obs_d()), 32'(rst_obs));
    chk("midreset_async_small", 32'(obs_s()), 32'(rst_obs));
    for (int i = 0; i < 4; i++) begin
      pix_en = (i % 2 == 0);
      @(posedge clk);
      #1;
      chk("midreset_hold_default", 32'(obs_d()), 32'(rst_obs));
    end
    @(negedge clk);
    rst = 1'b1;
    tcnt = 0;
    ep = 1'b0;
    mon_clear();
    step(1'b1);
    chk("post_reset_first_pixel",
        32'({video_on_d, pixel_x_d, pixel_y_d, line_start_d, frame_start_d}),
        32'({1'b1, 10'd0, 10'd0, 1'b0, 1'b0}));

    // pix_en tied high: same count behaviour at the clk rate.
    repeat (1100) step(1'b1);
    chk("hsync_low_clk_1to1", 32'(hs_len_d), 32'd96);
    chk("small_vsync_low_clk_1to1", 32'(vs_len_s), 32'd64);
    chk("small_frame_period_clk_1to1", 32'(fs_per_s), 32'd480);
    chk("scoreboard_drained", 32'(q_d.size() + q_s.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
